// File: rtl/sram_pkg.sv
// Shared widths and FSM state encoding for the asynchronous SRAM controller.
package sram_pkg;
    localparam int SRAM_AW = 20;
    localparam int SRAM_DW = 32;
    localparam int SRAM_BW = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD
    } state_e;
endpackage

// File: rtl/sram_controller.sv
// Single-port async SRAM controller: one request at a time, registered pins,
// programmable read strobe length and write pulse width.
module sram_controller
    import sram_pkg::*;
#(
    parameter int READ_WAIT   = 1,
    parameter int WRITE_PULSE = 1
) (
    input  logic               clk_50M,
    input  logic               reset_btn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [SRAM_AW-1:0] req_addr,
    input  logic [SRAM_DW-1:0] req_wdata,
    input  logic [SRAM_BW-1:0] req_be,
    output logic               resp_valid,
    output logic [SRAM_DW-1:0] resp_rdata,
    output logic [SRAM_AW-1:0] ram_addr,
    inout  wire  [SRAM_DW-1:0] ram_data,
    output logic               ram_ce_n,
    output logic               ram_oe_n,
    output logic               ram_we_n,
    output logic [SRAM_BW-1:0] ram_be_n
);
    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [SRAM_DW-1:0] wdata_q, wdata_d;
    logic [SRAM_BW-1:0] be_n_q, be_n_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               drive_q, drive_d;
    logic               resp_valid_q, resp_valid_d;
    logic [SRAM_DW-1:0] rdata_q, rdata_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_n_d       = be_n_q;
        ce_n_d       = ce_n_q;
        oe_n_d       = oe_n_q;
        we_n_d       = we_n_q;
        drive_d      = drive_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    ce_n_d  = 1'b0;
                    cnt_d   = 4'(READ_WAIT);
                    if (req_we) begin
                        state_d = ST_WR_SETUP;
                        be_n_d  = ~req_be;
                        drive_d = 1'b1;
                    end else begin
                        state_d = ST_READ;
                        oe_n_d  = 1'b0;
                        be_n_d  = '0;
                    end
                end
            end
            ST_READ: begin
                if (cnt_q == 4'd0) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b1;
                    rdata_d      = ram_data;
                    ce_n_d       = 1'b1;
                    oe_n_d       = 1'b1;
                    be_n_d       = '1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WR_SETUP: begin
                state_d = ST_WR_PULSE;
                we_n_d  = 1'b0;
                cnt_d   = 4'(WRITE_PULSE - 1);
            end
            ST_WR_PULSE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_WR_HOLD;
                    we_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WR_HOLD: begin
                // data stays on the bus one cycle past the rising we_n edge
                state_d      = ST_IDLE;
                resp_valid_d = 1'b1;
                ce_n_d       = 1'b1;
                be_n_d       = '1;
                drive_d      = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (reset_btn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_n_q       <= '1;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            drive_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_n_q       <= be_n_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            drive_q      <= drive_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign ram_addr   = addr_q;
    assign ram_be_n   = be_n_q;
    assign ram_ce_n   = ce_n_q;
    assign ram_oe_n   = oe_n_q;
    assign ram_we_n   = we_n_q;
    assign ram_data   = drive_q ? wdata_q : 'z;
endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: async SRAM model, directed table, corner sequences
// and random traffic against an address->word reference map.
module tb_sram_controller;
    localparam int RW = 1;
    localparam int WP = 1;

    logic        clk = 1'b0;
    logic        reset_btn = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [19:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [19:0] ram_addr;
    wire  [31:0] ram_data;
    logic        ram_ce_n, ram_oe_n, ram_we_n;
    logic [3:0]  ram_be_n;

    sram_controller #(.READ_WAIT(RW), .WRITE_PULSE(WP)) dut (
        .clk_50M(clk), .reset_btn(reset_btn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
        .ram_be_n(ram_be_n)
    );

    always #10 clk = ~clk;

    // SRAM model: 1024 words, addresses folded to {a[19:18], a[7:0]}
    logic [31:0] mem [0:1023];
    function automatic int idx(input logic [19:0] a);
        return int'({a[19:18], a[7:0]});
    endfunction
    assign ram_data = (!ram_ce_n && !ram_oe_n) ? mem[idx(ram_addr)] : 'z;
    always @(posedge clk) begin
        if (!ram_ce_n && !ram_we_n)
            for (int b = 0; b < 4; b++)
                if (!ram_be_n[b]) mem[idx(ram_addr)][8*b +: 8] <= ram_data[8*b +: 8];
    end

    int total = 0;
    int bad = 0;
    int viol = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Pin-level protocol watchdog
    logic [19:0] prev_addr;
    logic [3:0]  prev_be_n;
    logic        prev_ce_n = 1'b1;
    always @(negedge clk) begin
        if (!reset_btn) begin
            if (!ram_oe_n && !ram_we_n) viol++;
            if (ram_ce_n && (!ram_oe_n || !ram_we_n)) viol++;
            if (!prev_ce_n && !ram_ce_n && (ram_addr !== prev_addr || ram_be_n !== prev_be_n)) viol++;
        end
        prev_ce_n <= ram_ce_n;
        prev_addr <= ram_addr;
        prev_be_n <= ram_be_n;
    end

    // Reference model: word map with byte-lane merge
    logic [31:0] ref_mem [logic [19:0]];
    function automatic logic [31:0] ref_rd(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction
    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (o & ~m) | (d & m);
    endfunction

    // One request; lat = cycles from accept to resp (-1 on timeout),
    // strobes = cycles with the relevant strobe (oe_n or we_n) low.
    task automatic do_req(input logic we, input logic [19:0] a, input logic [31:0] d,
                          input logic [3:0] be, output logic [31:0] rd,
                          output int lat, output int strobes);
        int n;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_be = be;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = -1; strobes = 0; rd = '0;
        for (n = 1; n <= 100; n++) begin
            if (!we && !ram_oe_n) strobes++;
            if (we && !ram_we_n) strobes++;
            if (resp_valid) begin lat = n; rd = resp_rdata; break; end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic        we;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [9];
    logic [19:0] pool [8];
    logic [31:0] rd;
    int          lat, strb, n1, n2, nresp;
    logic [31:0] r2;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        vecs[0] = '{1'b1, 20'hC0000, 32'hAAAAAAAA, 4'hF, 32'h0};
        vecs[1] = '{1'b0, 20'hC0000, 32'h0,        4'h0, 32'hAAAAAAAA};
        vecs[2] = '{1'b1, 20'h00010, 32'h12345678, 4'hF, 32'h0};
        vecs[3] = '{1'b0, 20'h00010, 32'h0,        4'h0, 32'h12345678};
        vecs[4] = '{1'b1, 20'h00020, 32'hFFFFFFFF, 4'hF, 32'h0};
        vecs[5] = '{1'b1, 20'h00020, 32'h0000AB00, 4'h2, 32'h0};
        vecs[6] = '{1'b0, 20'h00020, 32'h0,        4'h0, 32'hFFFFABFF};
        vecs[7] = '{1'b1, 20'h00030, 32'h55555555, 4'h0, 32'h0};
        vecs[8] = '{1'b0, 20'h00030, 32'h0,        4'h0, 32'h00000000};
        pool = '{20'h00080, 20'h40081, 20'h80082, 20'hC0083,
                 20'h000F0, 20'h400F1, 20'h00010, 20'hC00FF};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_addr", 32'(ram_addr), 32'h0);
        chk("rst_strobes", {29'b0, ram_ce_n, ram_oe_n, ram_we_n}, 32'h7);
        chk("rst_be_n", 32'(ram_be_n), 32'hF);
        reset_btn = 1'b0;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, lat, strb);
            chk($sformatf("tbl%0d_lat", i), 32'(lat), vecs[i].we ? 32'(WP + 3) : 32'(RW + 2));
            chk($sformatf("tbl%0d_strobe", i), 32'(strb), vecs[i].we ? 32'(WP) : 32'(RW + 1));
            if (vecs[i].we)
                ref_mem[vecs[i].addr] = merge(ref_rd(vecs[i].addr), vecs[i].wdata, vecs[i].be);
            else
                chk($sformatf("tbl%0d_rdata", i), rd, vecs[i].exp);
        end

        // Back-to-back write then read with req_valid held high
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 20'h00050;
        req_wdata = 32'hDEADBEEF; req_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b0;
        n1 = -1; n2 = -1; nresp = 0; r2 = '0;
        for (int n = 1; n <= 12; n++) begin
            if (n == 5) req_valid = 1'b0;
            if (resp_valid) begin
                nresp++;
                if (n1 < 0) begin
                    n1 = n;
                    chk("b2b_ready_on_resp", 32'(req_ready), 32'd1);
                end else begin
                    n2 = n; r2 = resp_rdata;
                end
            end
            @(negedge clk);
        end
        ref_mem[20'h00050] = 32'hDEADBEEF;
        chk("b2b_first_resp", 32'(n1), 32'(WP + 3));
        chk("b2b_second_resp", 32'(n2), 32'(WP + 3 + RW + 2));
        chk("b2b_rdata", r2, 32'hDEADBEEF);
        chk("b2b_nresp", 32'(nresp), 32'd2);

        // req_valid pulsed while a read is in flight
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 20'h00010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_wdata = 32'h0; req_be = 4'hF;
        nresp = 0; r2 = '0;
        for (int n = 1; n <= 10; n++) begin
            if (n == 2) req_valid = 1'b0;
            if (resp_valid) begin nresp++; r2 = resp_rdata; end
            @(negedge clk);
        end
        chk("busy_nresp", 32'(nresp), 32'd1);
        chk("busy_rdata", r2, 32'h12345678);
        do_req(1'b0, 20'h00010, 32'h0, 4'h0, rd, lat, strb);
        chk("busy_no_side_effect", rd, 32'h12345678);

        // Reset during the write pulse
        do_req(1'b1, 20'h00040, 32'h0, 4'hF, rd, lat, strb);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 20'h00040;
        req_wdata = 32'h5A5A5A5A; req_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_in_pulse", 32'(ram_we_n), 32'd0);
        reset_btn = 1'b1;
        @(negedge clk);
        chk("rstmid_we_n", 32'(ram_we_n), 32'd1);
        chk("rstmid_ce_n", 32'(ram_ce_n), 32'd1);
        chk("rstmid_resp", 32'(resp_valid), 32'd0);
        chk("rstmid_ready", 32'(req_ready), 32'd1);
        chk("rstmid_rdata", resp_rdata, 32'h0);
        reset_btn = 1'b0;
        nresp = 0;
        repeat (6) begin @(negedge clk); if (resp_valid) nresp++; end
        chk("rstmid_no_resp", 32'(nresp), 32'd0);
        do_req(1'b0, 20'h00040, 32'h0, 4'h0, rd, lat, strb);
        total++;
        if (rd !== 32'h0 && rd !== 32'h5A5A5A5A) begin
            bad++;
            $display("FAIL rstmid_word: got %h want 00000000 or 5a5a5a5a", rd);
        end
        ref_mem[20'h00040] = rd;

        // Random traffic against the reference map
        for (int i = 0; i < 60; i++) begin
            logic        we;
            logic [19:0] a;
            logic [31:0] d;
            logic [3:0]  be;
            we = 1'($urandom);
            a  = pool[$urandom_range(0, 7)];
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            do_req(we, a, d, be, rd, lat, strb);
            chk($sformatf("rnd%0d_lat", i), 32'(lat), we ? 32'(WP + 3) : 32'(RW + 2));
            if (we) ref_mem[a] = merge(ref_rd(a), d, be);
            else    chk($sformatf("rnd%0d_rdata", i), rd, ref_rd(a));
        end

        chk("protocol_violations", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
